// File: rtl/mcu_pmu_pkg.sv
// Shared definitions for the deep-sleep power management sequencer.
// Holds the state encodings, the counter width and the output decode.
package mcu_pmu_pkg;

  localparam int MCU_PMU_WAKE_CYCLES_DEFAULT = 16;
  localparam int MCU_PMU_CNT_W               = 8;

  typedef logic [MCU_PMU_CNT_W-1:0] pmu_cnt_t;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_HOLDREQ = 3'd1,
    ST_PWRREQ  = 3'd2,
    ST_LOWPWR  = 3'd3,
    ST_PWRREL  = 3'd4,
    ST_SETTLE  = 3'd5,
    ST_HOLDREL = 3'd6
  } pmu_state_t;

  typedef struct packed {
    logic sleephold_req_n;
    logic stop_req;
    logic stby_req;
    logic hclk_en;
  } pmu_outs_t;

  localparam pmu_outs_t PMU_OUTS_RESET = '{sleephold_req_n: 1'b1, stop_req: 1'b0,
                                           stby_req: 1'b0, hclk_en: 1'b1};

  // Output levels implied by a state; power requests follow the latched mode.
  function automatic pmu_outs_t pmu_decode(input pmu_state_t st, input logic mode_sb);
    pmu_outs_t o;
    logic      pwr_req;
    o                 = PMU_OUTS_RESET;
    pwr_req           = (st == ST_PWRREQ) || (st == ST_LOWPWR);
    o.sleephold_req_n = !((st == ST_HOLDREQ) || (st == ST_PWRREQ) || (st == ST_LOWPWR) ||
                          (st == ST_PWRREL) || (st == ST_SETTLE));
    o.stop_req        = pwr_req && !mode_sb;
    o.stby_req        = pwr_req && mode_sb;
    o.hclk_en         = !((st == ST_LOWPWR) || (st == ST_PWRREL) || (st == ST_SETTLE));
    return o;
  endfunction

endpackage

// File: rtl/mcu_pmu_if.sv
// Handshake bundle between the PMU and mcu_sysctrl / CPU sleep status.
// The PMU side is the master: it issues the hold and power requests.
interface mcu_pmu_if;

  logic       PMUENABLE;
  logic       PDDS_REG;
  logic       SLEEPING;
  logic       SLEEPDEEP;
  logic       WAKEUP;
  logic       SLEEPHOLDACKn;
  logic       STOPACK;
  logic       STBYACK;
  logic       PLL_LOCK;
  logic       SLEEPHOLDREQn;
  logic       STOPREQ;
  logic       STBYREQ;
  logic       HCLKEN;
  logic [2:0] PMU_STATE;

  modport master (
    input  PMUENABLE, PDDS_REG, SLEEPING, SLEEPDEEP, WAKEUP,
    input  SLEEPHOLDACKn, STOPACK, STBYACK, PLL_LOCK,
    output SLEEPHOLDREQn, STOPREQ, STBYREQ, HCLKEN, PMU_STATE
  );

  modport slave (
    output PMUENABLE, PDDS_REG, SLEEPING, SLEEPDEEP, WAKEUP,
    output SLEEPHOLDACKn, STOPACK, STBYACK, PLL_LOCK,
    input  SLEEPHOLDREQn, STOPREQ, STBYREQ, HCLKEN, PMU_STATE
  );

endinterface

// File: rtl/mcu_pmu_settle_cnt.sv
// Loadable down-counter that saturates at zero, timing the post-wake settle.
module mcu_pmu_settle_cnt
  import mcu_pmu_pkg::*;
(
  input  logic     FCLK,
  input  logic     PORESETn,
  input  logic     load,
  input  pmu_cnt_t load_val,
  input  logic     dec,
  output logic     zero
);

  pmu_cnt_t count_q;

  always_ff @(posedge FCLK or negedge PORESETn) begin
    if (!PORESETn) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/mcu_pmu.sv
// Deep-sleep sequencer: hold -> power request -> clock gate, and the reverse
// on wake with PLL-lock and settle wait before HCLK is restored.
module mcu_pmu
  import mcu_pmu_pkg::*;
#(
  parameter int WAKE_CYCLES = MCU_PMU_WAKE_CYCLES_DEFAULT
) (
  input  logic      FCLK,
  input  logic      PORESETn,
  mcu_pmu_if.master bus
);

  localparam pmu_cnt_t SETTLE_LOAD = pmu_cnt_t'(WAKE_CYCLES - 1);

  pmu_state_t state_q, state_d;
  logic       mode_q, mode_d;
  pmu_outs_t  outs_q, outs_d;
  logic       sel_ack;
  logic       cnt_load;
  logic       cnt_zero;

  assign sel_ack = mode_q ? bus.STBYACK : bus.STOPACK;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cnt_load = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.PMUENABLE && bus.SLEEPING && bus.SLEEPDEEP && !bus.WAKEUP) begin
          state_d = ST_HOLDREQ;
          mode_d  = bus.PDDS_REG;
        end
      end
      ST_HOLDREQ: begin
        if (bus.WAKEUP)              state_d = ST_HOLDREL;
        else if (!bus.SLEEPHOLDACKn) state_d = ST_PWRREQ;
      end
      ST_PWRREQ: begin
        if (bus.WAKEUP)   state_d = ST_PWRREL;
        else if (sel_ack) state_d = ST_LOWPWR;
      end
      ST_LOWPWR: begin
        if (bus.WAKEUP) state_d = ST_PWRREL;
      end
      ST_PWRREL: begin
        if (!sel_ack) begin
          state_d  = ST_SETTLE;
          cnt_load = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_zero && bus.PLL_LOCK) state_d = ST_HOLDREL;
      end
      ST_HOLDREL: begin
        if (bus.SLEEPHOLDACKn) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  assign outs_d = pmu_decode(state_d, mode_d);

  always_ff @(posedge FCLK or negedge PORESETn) begin
    if (!PORESETn) begin
      state_q <= ST_RUN;
      mode_q  <= 1'b0;
      outs_q  <= PMU_OUTS_RESET;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      outs_q  <= outs_d;
    end
  end

  mcu_pmu_settle_cnt u_settle_cnt (
    .FCLK     (FCLK),
    .PORESETn (PORESETn),
    .load     (cnt_load),
    .load_val (SETTLE_LOAD),
    .dec      (state_q == ST_SETTLE),
    .zero     (cnt_zero)
  );

  assign bus.SLEEPHOLDREQn = outs_q.sleephold_req_n;
  assign bus.STOPREQ       = outs_q.stop_req;
  assign bus.STBYREQ       = outs_q.stby_req;
  assign bus.HCLKEN        = outs_q.hclk_en;
  assign bus.PMU_STATE     = state_q;

endmodule

// File: tb/tb_mcu_pmu.sv
// Self-checking bench for mcu_pmu: directed vector tables, hand-written corner
// sequences and randomized traffic against a cycle-level reference model.
module tb_mcu_pmu;

  localparam int WAKE = 4;

  // Stimulus bits: {en, pdds, sleeping, deep, wake, ackn, stopack, stbyack, lock}
  // Expected bits: {state[2:0], holdreq_n, stopreq, stbyreq, hclken}
  typedef struct {
    logic [8:0] stim;
    logic [6:0] exp;
  } vec_t;

  localparam logic [6:0] OUT_RESET = 7'b000_1_0_0_1;

  logic FCLK;
  logic PORESETn;
  int   checks;
  int   errors;

  int   m_state;
  int   m_wait;
  bit   m_mode;

  mcu_pmu_if bus ();

  mcu_pmu #(.WAKE_CYCLES(WAKE)) dut (
    .FCLK     (FCLK),
    .PORESETn (PORESETn),
    .bus      (bus)
  );

  initial FCLK = 1'b0;
  always #5 FCLK = ~FCLK;

  task automatic modelReset();
    m_state = 0;
    m_wait  = 0;
    m_mode  = 1'b0;
  endtask

  // Sequencer rules, one FCLK edge at a time; m_wait counts settle cycles spent.
  task automatic modelStep();
    int  ns;
    bit  ack;
    ns  = m_state;
    ack = m_mode ? bus.STBYACK : bus.STOPACK;
    case (m_state)
      0: if (bus.PMUENABLE && bus.SLEEPING && bus.SLEEPDEEP && !bus.WAKEUP) begin
           ns = 1;
           m_mode = bus.PDDS_REG;
         end
      1: if (bus.WAKEUP) ns = 6; else if (!bus.SLEEPHOLDACKn) ns = 2;
      2: if (bus.WAKEUP) ns = 4; else if (ack) ns = 3;
      3: if (bus.WAKEUP) ns = 4;
      4: if (!ack) begin ns = 5; m_wait = 0; end
      5: if ((m_wait >= WAKE - 1) && bus.PLL_LOCK) ns = 6; else m_wait++;
      6: if (bus.SLEEPHOLDACKn) ns = 0;
      default: ns = 0;
    endcase
    m_state = ns;
  endtask

  function automatic logic [6:0] modelOut();
    logic [2:0] st;
    bit         pw;
    st = 3'(m_state);
    pw = (m_state == 2) || (m_state == 3);
    return {st, !(m_state >= 1 && m_state <= 5), pw && !m_mode, pw && m_mode,
            !(m_state >= 3 && m_state <= 5)};
  endfunction

  task automatic applyStimulus(input logic [8:0] s);
    {bus.PMUENABLE, bus.PDDS_REG, bus.SLEEPING, bus.SLEEPDEEP, bus.WAKEUP,
     bus.SLEEPHOLDACKn, bus.STOPACK, bus.STBYACK, bus.PLL_LOCK} = s;
    modelStep();
    @(posedge FCLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = {bus.PMU_STATE, bus.SLEEPHOLDREQn, bus.STOPREQ, bus.STBYREQ, bus.HCLKEN};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got state/hold_n/stop/stby/hclken=%b, expected %b", name, act, exp);
    end
  endtask

  task automatic runTable(input string name, input vec_t tbl[$]);
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].stim);
      checkOutput($sformatf("%s[%0d]", name, i), tbl[i].exp);
      checkOutput($sformatf("%s_model[%0d]", name, i), modelOut());
    end
  endtask

  initial begin
    vec_t stop_tbl[$];
    vec_t stby_tbl[$];
    vec_t abort_tbl[$];
    logic [8:0] s;

    checks = 0;
    errors = 0;
    modelReset();
    {bus.PMUENABLE, bus.PDDS_REG, bus.SLEEPING, bus.SLEEPDEEP, bus.WAKEUP,
     bus.SLEEPHOLDACKn, bus.STOPACK, bus.STBYACK, bus.PLL_LOCK} = 9'b0_0_0_0_0_1_0_0_1;

    stop_tbl = '{
      '{9'b1_0_1_1_0_1_0_0_1, 7'b001_0_0_0_1},
      '{9'b1_0_1_1_0_0_0_0_1, 7'b010_0_1_0_1},
      '{9'b1_0_1_1_0_0_1_0_1, 7'b011_0_1_0_0},
      '{9'b1_0_1_1_0_0_1_0_1, 7'b011_0_1_0_0},
      '{9'b1_0_1_1_1_0_1_0_1, 7'b100_0_0_0_0},
      '{9'b1_0_1_1_0_0_0_0_1, 7'b101_0_0_0_0},
      '{9'b1_0_1_1_0_0_0_0_1, 7'b101_0_0_0_0},
      '{9'b1_0_1_1_0_0_0_0_1, 7'b101_0_0_0_0},
      '{9'b1_0_1_1_0_0_0_0_1, 7'b101_0_0_0_0},
      '{9'b1_0_1_1_0_0_0_0_1, 7'b110_1_0_0_1},
      '{9'b1_0_0_0_0_1_0_0_1, 7'b000_1_0_0_1}
    };
    stby_tbl = '{
      '{9'b1_1_1_1_0_1_0_0_1, 7'b001_0_0_0_1},
      '{9'b1_1_1_1_0_0_0_0_1, 7'b010_0_0_1_1},
      '{9'b1_1_1_1_0_0_0_1_1, 7'b011_0_0_1_0},
      '{9'b1_0_1_1_0_0_0_1_1, 7'b011_0_0_1_0},
      '{9'b1_0_1_1_1_0_1_1_1, 7'b100_0_0_0_0},
      '{9'b1_0_1_1_0_0_1_1_1, 7'b100_0_0_0_0},
      '{9'b1_0_1_1_0_0_1_0_1, 7'b101_0_0_0_0},
      '{9'b1_0_1_1_0_0_0_0_1, 7'b101_0_0_0_0},
      '{9'b1_0_1_1_0_0_0_0_1, 7'b101_0_0_0_0},
      '{9'b1_0_1_1_0_0_0_0_1, 7'b101_0_0_0_0},
      '{9'b1_0_1_1_0_0_0_0_1, 7'b110_1_0_0_1},
      '{9'b1_0_0_0_0_1_0_0_1, 7'b000_1_0_0_1}
    };
    abort_tbl = '{
      '{9'b1_0_1_1_0_1_0_0_1, 7'b001_0_0_0_1},
      '{9'b1_0_1_1_1_1_0_0_1, 7'b110_1_0_0_1},
      '{9'b1_0_0_0_0_1_0_0_1, 7'b000_1_0_0_1}
    };

    PORESETn = 1'b0;
    repeat (3) @(posedge FCLK);
    #1;
    checkOutput("reset_held", OUT_RESET);
    @(negedge FCLK);
    PORESETn = 1'b1;
    @(posedge FCLK);
    #1;
    checkOutput("reset_released", OUT_RESET);

    $display("[TB] stop entry/exit");
    runTable("stop", stop_tbl);
    $display("[TB] standby select");
    runTable("stby", stby_tbl);
    $display("[TB] wake abort in HOLDREQ");
    runTable("abort", abort_tbl);

    $display("[TB] PLL lock wait");
    applyStimulus(9'b1_0_1_1_0_1_0_0_1);
    applyStimulus(9'b1_0_1_1_0_0_0_0_1);
    applyStimulus(9'b1_0_1_1_0_0_1_0_1);
    applyStimulus(9'b1_0_1_1_1_0_1_0_1);
    checkOutput("pll_pwrrel", 7'b100_0_0_0_0);
    for (int i = 0; i < 50; i++) begin
      applyStimulus(9'b1_0_1_1_0_0_0_0_0);
      checkOutput($sformatf("pll_wait[%0d]", i), 7'b101_0_0_0_0);
    end
    applyStimulus(9'b1_0_1_1_0_0_0_0_1);
    checkOutput("pll_locked", 7'b110_1_0_0_1);
    applyStimulus(9'b1_0_0_0_0_1_0_0_1);
    checkOutput("pll_run", OUT_RESET);

    $display("[TB] PMUENABLE gating");
    for (int i = 0; i < 100; i++) begin
      applyStimulus(9'b0_0_1_1_0_1_0_0_1);
      checkOutput($sformatf("gated[%0d]", i), OUT_RESET);
    end

    $display("[TB] reset during LOWPWR");
    applyStimulus(9'b1_0_1_1_0_1_0_0_1);
    applyStimulus(9'b1_0_1_1_0_0_0_0_1);
    applyStimulus(9'b1_0_1_1_0_0_1_0_1);
    checkOutput("lowpwr_before_reset", 7'b011_0_1_0_0);
    #2;
    PORESETn = 1'b0;
    modelReset();
    #1;
    checkOutput("async_reset", OUT_RESET);
    {bus.SLEEPING, bus.SLEEPDEEP} = 2'b00;
    @(negedge FCLK);
    PORESETn = 1'b1;
    applyStimulus(9'b1_0_0_0_0_1_0_0_1);
    checkOutput("after_reset", OUT_RESET);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      logic [6:0] mo;
      mo = modelOut();
      s[8] = ($urandom_range(0, 7) != 0);
      s[7] = 1'($urandom_range(0, 1));
      s[6] = ($urandom_range(0, 3) != 0);
      s[5] = ($urandom_range(0, 3) != 0);
      s[4] = ($urandom_range(0, 5) == 0);
      s[3] = mo[3] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      s[2] = mo[2] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      s[1] = mo[1] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      s[0] = ($urandom_range(0, 3) != 0);
      applyStimulus(s);
      checkOutput($sformatf("random[%0d]", i), modelOut());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcu_pmu.md
# mcu_pmu

Power management sequencer sitting directly upstream of `mcu_sysctrl` on the free-running `FCLK` domain. When the CPU enters deep sleep, it issues the sleep-hold and stop/standby requests that `mcu_sysctrl` acknowledges, then gates `HCLK`. On wake-up it reverses the sequence, waiting for PLL lock and a settle delay before restoring the clock. Standby or stop is selected by `PDDS_REG`, and the sequence is enabled by `PMUENABLE`, both produced by `mcu_sysctrl`.

## Interface
Parameters:
- `WAKE_CYCLES`, default 16: settle delay in `FCLK` cycles after power-request release, before `HCLK` is re-enabled. Legal range 1..255.

Ports:
- Clock and reset: one clock, `FCLK`; reset `PORESETn` is asynchronous and active-low.
- `FCLK` in 1: free-running clock; all logic on its rising edge.
- `PORESETn` in 1: asynchronous active-low power-on reset.
- `PMUENABLE` in 1: enables deep-sleep sequencing; 0 keeps the block in RUN.
- `PDDS_REG` in 1: 1 selects standby (`STBYREQ`), 0 selects stop (`STOPREQ`); sampled on leaving RUN.
- `SLEEPING` in 1: CPU is asleep.
- `SLEEPDEEP` in 1: sleep is deep sleep.
- `WAKEUP` in 1: wake event, level, synchronous to `FCLK` (OR of the interrupt or WIC wake lines).
- `SLEEPHOLDACKn` in 1: hold acknowledge, active-low.
- `STOPACK` in 1: stop acknowledge.
- `STBYACK` in 1: standby acknowledge.
- `PLL_LOCK` in 1: PLL locked.
- `SLEEPHOLDREQn` out 1: hold request, active-low.
- `STOPREQ` out 1: stop-mode request.
- `STBYREQ` out 1: standby-mode request.
- `HCLKEN` out 1: clock-gate enable for `HCLK`.
- `PMU_STATE` out 3: current state encoding, for debug.

## Operation
- States and encodings: RUN=0, HOLDREQ=1, PWRREQ=2, LOWPWR=3, PWRREL=4, SETTLE=5, HOLDREL=6. The value 7 is illegal and recovers to RUN.
- RUN -> HOLDREQ when `PMUENABLE & SLEEPING & SLEEPDEEP & ~WAKEUP`. `PDDS_REG` is latched into `mode_sb` on this transition.
- HOLDREQ:
  - `SLEEPHOLDREQn`=0.
  - -> PWRREQ when `SLEEPHOLDACKn`=0.
  - `WAKEUP`=1 takes priority over the ack and goes -> HOLDREL (abort).
- PWRREQ:
  - `STBYREQ`=`mode_sb` and `STOPREQ`=`~mode_sb`.
  - -> LOWPWR when the selected ack is 1.
  - `WAKEUP`=1 takes priority and goes -> PWRREL (abort).
- LOWPWR: `HCLKEN`=0; -> PWRREL when `WAKEUP`=1.
- PWRREL:
  - Both power requests are 0 and `HCLKEN` stays 0.
  - -> SETTLE when the selected ack is 0.
  - The settle counter loads `WAKE_CYCLES-1` on this transition.
- SETTLE:
  - `HCLKEN`=0; the counter decrements each cycle and saturates at 0.
  - -> HOLDREL when counter==0 and `PLL_LOCK`=1.
  - If `PLL_LOCK` stays low, the block waits indefinitely with the counter held at 0.
- HOLDREL:
  - `HCLKEN`=1 and `SLEEPHOLDREQn`=1.
  - -> RUN when `SLEEPHOLDACKn`=1.
- Output summary:
  - `SLEEPHOLDREQn`=0 in HOLDREQ..SETTLE.
  - `HCLKEN`=0 in LOWPWR, PWRREL and SETTLE.
  - Power requests are 1 only in PWRREQ and LOWPWR.
- `WAKEUP` is ignored in PWRREL, SETTLE and HOLDREL; the wake sequence always completes.
- `PMUENABLE` falling mid-sequence has no effect; it is only checked in RUN.
- A `PDDS_REG` change mid-sequence has no effect because `mode_sb` is already latched.
- RUN is re-entered only through HOLDREL, so the hold is always released with the clock already running.

## Timing
- All outputs are registered and decoded from the state register; no combinational input-to-output paths.
- Reset values:
  - State=RUN, `PMU_STATE`=0.
  - `SLEEPHOLDREQn`=1, `STOPREQ`=0, `STBYREQ`=0, `HCLKEN`=1.
  - `mode_sb`=0, counter=0.
- Reset asserted mid-sequence returns immediately to the reset values, which ungates the clock.
- Each transition takes 1 cycle after its qualifying input is sampled high.
- Minimum entry latency, from the deep-sleep condition to `HCLKEN`=0, is 3 cycles with immediate acks.
- Minimum wake latency, from `WAKEUP` in LOWPWR to `HCLKEN`=1, is `WAKE_CYCLES`+2 cycles with an immediate ack drop and PLL already locked.
- No timeout on acks: the block waits indefinitely in any ack-wait state.

## Structure
- Shared package `mcu_pmu_pkg`: state encodings, `MCU_PMU_WAKE_CYCLES_DEFAULT`=16, counter width 8.
- Natural sub-module: `mcu_pmu_settle_cnt`, a loadable saturating down-counter with a `zero` flag.
- Everything else stays in the top module.

## Test plan
- Stop entry/exit:
  - Stimulus: `PMUENABLE`=1, `PDDS_REG`=0, `SLEEPING`=`SLEEPDEEP`=1, acks immediate, `WAKE_CYCLES`=4.
  - Required: `PMU_STATE` goes 1,2,3; `STOPREQ`=1 and `STBYREQ`=0; `HCLKEN`=0 after 3 cycles.
  - Then `WAKEUP` pulse: `HCLKEN`=1 exactly 6 cycles later, then return to RUN.
- Standby select: `PDDS_REG`=1 at entry, toggled to 0 in LOWPWR -> `STBYREQ` stays 1 and `STOPREQ` never asserts.
- Abort: `WAKEUP`=1 in HOLDREQ with `SLEEPHOLDACKn` still 1 -> next state HOLDREL; no power request is ever asserted; `HCLKEN` never goes 0.
- PLL wait: `PLL_LOCK`=0 during SETTLE for 50 cycles -> state stays 5 and `HCLKEN`=0; `PLL_LOCK` rises -> HOLDREL next cycle.
- Gating: `PMUENABLE`=0 with deep sleep asserted -> state stays RUN for 100 cycles and outputs hold their reset values.
- Reset mid-LOWPWR: pulse `PORESETn` low -> same cycle `HCLKEN`=1, `SLEEPHOLDREQn`=1, both power requests 0, `PMU_STATE`=0.
